// File: rtl/oneshot_pulse_bank_pkg.sv
// rtl/oneshot_pulse_bank_pkg.sv - shared types and defaults for the one-shot pulse bank
package oneshot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } oneshot_state_t;

    localparam int ONESHOT_N_CH   = 4;
    localparam int ONESHOT_DATA_W = 8;
    localparam int ONESHOT_CNT_W  = 4;

endpackage

// File: rtl/oneshot_pulse_bank_channel.sv
// rtl/oneshot_pulse_bank_channel.sv - one one-shot channel: FSM, length counter, data register
module oneshot_channel
    import oneshot_pkg::*;
#(
    parameter int DATA_W = ONESHOT_DATA_W,
    parameter int CNT_W  = ONESHOT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    input  logic [CNT_W-1:0]  len,
    input  logic              rep,
    output logic [DATA_W-1:0] q,
    output logic              active,
    output logic              done
);

    oneshot_state_t   state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        q     <= d;
                        // cnt holds cycles remaining after the current one; length 0 acts as 1
                        cnt   <= (len == '0) ? '0 : len - CNT_W'(1);
                        state <= PULSE;
                    end else begin
                        q <= '0;
                    end
                end
                PULSE: begin
                    if (!en) begin
                        q     <= '0;
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        q     <= '0;
                        done  <= 1'b1;
                        state <= rep ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    q <= '0;
                    if (!en) state <= IDLE;
                end
                default: begin
                    q     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign active = (state == PULSE);

endmodule

// File: rtl/oneshot_pulse_bank.sv
// rtl/oneshot_pulse_bank.sv - bank of independent one-shot pulse channels
module oneshot_pulse_bank
    import oneshot_pkg::*;
#(
    parameter int N_CH   = ONESHOT_N_CH,
    parameter int DATA_W = ONESHOT_DATA_W,
    parameter int CNT_W  = ONESHOT_CNT_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_CH-1:0]          i_en,
    input  logic [N_CH*DATA_W-1:0]   i_d,
    input  logic [N_CH*CNT_W-1:0]    i_len,
    input  logic [N_CH-1:0]          i_repeat,
    output logic [N_CH*DATA_W-1:0]   o_q,
    output logic [N_CH-1:0]          o_active,
    output logic [N_CH-1:0]          o_done
);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        oneshot_channel #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .en     (i_en[k]),
            .d      (i_d[k*DATA_W +: DATA_W]),
            .len    (i_len[k*CNT_W +: CNT_W]),
            .rep    (i_repeat[k]),
            .q      (o_q[k*DATA_W +: DATA_W]),
            .active (o_active[k]),
            .done   (o_done[k])
        );
    end

endmodule
